// File: rtl/uart_boot_loader.sv
// Boot loader: parses a framed image from the RX FIFO into RAM, then releases the core.
// Ports: clk/rst, fifo_empty/fifo_q/fifo_rdreq, ram_addr/ram_data/ram_we, core_run, boot_busy, boot_err, tx_full/tx_wrreq/tx_data.
// Option: define UART_BOOT_ECHO_EN to echo every captured byte to the TX FIFO.
module uart_boot_loader #(
  parameter int          ADDR_W    = 13,
  parameter logic [7:0]  SYNC_BYTE = 8'h55,
  parameter int          MAX_WORDS = 8192
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [7:0]        fifo_q,
  output logic              fifo_rdreq,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_data,
  output logic              ram_we,
  output logic              core_run,
  output logic              boot_busy,
  output logic              boot_err,
  input  logic              tx_full,
  output logic              tx_wrreq,
  output logic [7:0]        tx_data
);

  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, DATA, WRITE, CSUM, DONE
  } state_t;

  state_t            state;
  logic              pend;
  logic [1:0]        bcnt;
  logic [ADDR_W:0]   wcnt;
  logic [7:0]        csum;
  logic [15:0]       len;
  logic [23:0]       acc;
  logic              need;
  logic [15:0]       len_new;

  assign need = (state == IDLE) || (state == LEN_LO) ||
                (state == LEN_HI) || (state == DATA) ||
                (state == CSUM);

  // Combinational so it can never fire on a stale empty flag.
  assign fifo_rdreq = !rst && need && !fifo_empty && !pend;

  assign len_new   = {fifo_q, len[7:0]};
  assign boot_busy = (state != IDLE) && (state != DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pend     <= 1'b0;
      bcnt     <= '0;
      wcnt     <= '0;
      csum     <= '0;
      len      <= '0;
      acc      <= '0;
      ram_addr <= '0;
      ram_data <= '0;
      ram_we   <= 1'b0;
      core_run <= 1'b0;
      boot_err <= 1'b0;
    end else begin
      pend   <= fifo_rdreq;
      ram_we <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pend && fifo_q == SYNC_BYTE) begin
            boot_err <= 1'b0;
            csum     <= '0;
            wcnt     <= '0;
            state    <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (pend) begin
            len[7:0] <= fifo_q;
            csum     <= csum ^ fifo_q;
            state    <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (pend) begin
            len  <= len_new;
            csum <= csum ^ fifo_q;
            if (32'(len_new) > 32'(MAX_WORDS)) begin
              boot_err <= 1'b1;
              state    <= IDLE;
            end else if (len_new == 16'd0) begin
              state <= CSUM;
            end else begin
              bcnt  <= '0;
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (pend) begin
            csum <= csum ^ fifo_q;
            bcnt <= bcnt + 2'd1;
            // Shift in LSB-first; the 4th byte lands on top.
            if (bcnt == 2'd3) begin
              ram_we   <= 1'b1;
              ram_addr <= wcnt[ADDR_W-1:0];
              ram_data <= {fifo_q, acc};
              state    <= WRITE;
            end else begin
              acc <= {fifo_q, acc[23:8]};
            end
          end
        end
        WRITE: begin
          wcnt <= wcnt + 1'b1;
          if (32'(wcnt) + 32'd1 == 32'(len)) begin
            state <= CSUM;
          end else begin
            bcnt  <= '0;
            state <= DATA;
          end
        end
        CSUM: begin
          if (pend) begin
            if (fifo_q == csum) begin
              core_run <= 1'b1;
              state    <= DONE;
            end else begin
              boot_err <= 1'b1;
              state    <= IDLE;
            end
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UART_BOOT_ECHO_EN
  logic       echo_v;
  logic [7:0] echo_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      echo_v <= 1'b0;
      echo_b <= '0;
    end else begin
      echo_v <= pend;
      if (pend) echo_b <= fifo_q;
    end
  end

  // A full TX FIFO drops the echo; loading never waits.
  assign tx_wrreq = echo_v && !tx_full;
  assign tx_data  = echo_b;
`else
  logic unused_tx_full;
  assign unused_tx_full = tx_full;
  assign tx_wrreq = 1'b0;
  assign tx_data  = 8'h00;
`endif

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: FIFO model feeds frames, RAM/TX writes are logged.
// Define UART_BOOT_ECHO_EN to include the echo scenario.
module tb_uart_boot_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_q = 8'h00;
  logic        fifo_rdreq;
  logic [12:0] ram_addr;
  logic [31:0] ram_data;
  logic        ram_we;
  logic        core_run;
  logic        boot_busy;
  logic        boot_err;
  logic        tx_full = 1'b0;
  logic        tx_wrreq;
  logic [7:0]  tx_data;

  uart_boot_loader dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_q     (fifo_q),
    .fifo_rdreq (fifo_rdreq),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .ram_we     (ram_we),
    .core_run   (core_run),
    .boot_busy  (boot_busy),
    .boot_err   (boot_err),
    .tx_full    (tx_full),
    .tx_wrreq   (tx_wrreq),
    .tx_data    (tx_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0]  q[$];
  logic [12:0] alog[$];
  logic [31:0] wlog[$];
  logic [7:0]  txlog[$];

  int         cyc = 0;
  int         last_pop = 0;
  int         run_cyc = -1;
  int         rd_bad = 0;
  logic [7:0] last_byte = 8'h00;
  bit         hold = 1'b0;
  bit         rnd = 1'b0;
  bit         full33 = 1'b0;

  logic [7:0] frame_ok[12] = '{8'h55, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33,
                               8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h46};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rdreq) begin
      if (fifo_empty || q.size() == 0) begin
        rd_bad <= rd_bad + 1;
      end else begin
        last_byte <= q[0];
        fifo_q    <= q.pop_front();
        last_pop  <= cyc;
      end
    end
    if (ram_we) begin
      alog.push_back(ram_addr);
      wlog.push_back(ram_data);
    end
    if (tx_wrreq) txlog.push_back(tx_data);
  end

  always @(negedge clk) begin
    fifo_empty = (rnd ? ($urandom_range(0, 1) == 1) : hold) || (q.size() == 0);
    tx_full = full33 && (tx_data == 8'h33);
    if (core_run && run_cyc < 0) run_cyc = cyc;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    alog.delete();
    wlog.delete();
    txlog.delete();
    run_cyc = -1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    hold = 1'b1;
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    clear_logs();
    hold = 1'b0;
  endtask

  task automatic push_frame(input logic [7:0] f[12]);
    foreach (f[i]) q.push_back(f[i]);
  endtask

  task automatic wait_run(input string tag, input int n);
    for (int i = 0; i < n && !core_run; i++) @(negedge clk);
    @(negedge clk);
    check(tag, {31'd0, core_run}, 32'd1);
  endtask

  task automatic wait_drain(input int n);
    for (int i = 0; i < n && q.size() != 0; i++) @(negedge clk);
    repeat (12) @(negedge clk);
  endtask

  task automatic check_log(input string tag);
    check({tag, "_n"}, alog.size(), 2);
    check({tag, "_a0"}, (alog.size() > 0) ? 32'(alog[0]) : 32'hFFFF_FFFF, 32'd0);
    check({tag, "_d0"}, (wlog.size() > 0) ? wlog[0] : 32'hFFFF_FFFF, 32'h4433_2211);
    check({tag, "_a1"}, (alog.size() > 1) ? 32'(alog[1]) : 32'hFFFF_FFFF, 32'd1);
    check({tag, "_d1"}, (wlog.size() > 1) ? wlog[1] : 32'hFFFF_FFFF, 32'hDDCC_BBAA);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"},
          {26'd0, core_run, boot_busy, boot_err, ram_we, fifo_rdreq, tx_wrreq},
          32'd0);
    check({tag, "_addr"}, 32'(ram_addr), 32'd0);
    check({tag, "_data"}, ram_data, 32'd0);
    check({tag, "_tx"}, 32'(tx_data), 32'd0);
  endtask

  initial begin
    logic [7:0] bad[12];
    logic [7:0] echo_exp[11];
    int lim;

    // Test 1: nominal frame
    do_reset();
    check_zero("rst");
    push_frame(frame_ok);
    wait_run("t1_run", 300);
    check("t1_run_lat", run_cyc - last_pop, 32'd2);
    check_log("t1");
    check("t1_err", {31'd0, boot_err}, 32'd0);
    check("t1_busy", {31'd0, boot_busy}, 32'd0);
    q.push_back(8'h55);
    repeat (20) @(negedge clk);
    check("t1_noread", q.size(), 1);

    // Test 2: bad checksum, then recovery
    do_reset();
    bad = frame_ok;
    bad[11] = 8'h47;
    push_frame(bad);
    wait_drain(300);
    check_log("t2");
    check("t2_err", {31'd0, boot_err}, 32'd1);
    check("t2_run", {31'd0, core_run}, 32'd0);
    check("t2_busy", {31'd0, boot_busy}, 32'd0);
    clear_logs();
    push_frame(frame_ok);
    lim = 0;
    while (!boot_busy && lim < 100) begin
      @(negedge clk);
      lim++;
    end
    check("t2_busy_seen", {31'd0, boot_busy}, 32'd1);
    check("t2_errclr", {31'd0, boot_err}, 32'd0);
    wait_run("t2_run2", 300);
    check_log("t2b");

    // Test 3: zero-length frame, then oversize length
    do_reset();
    q.push_back(8'h55);
    q.push_back(8'h00);
    q.push_back(8'h00);
    q.push_back(8'h00);
    wait_run("t3_run", 100);
    check("t3_nowe", alog.size(), 0);
    do_reset();
    q.push_back(8'h55);
    q.push_back(8'h01);
    q.push_back(8'h21);
    wait_drain(100);
    check("t3_err", {31'd0, boot_err}, 32'd1);
    check("t3_busy", {31'd0, boot_busy}, 32'd0);
    check("t3_run", {31'd0, core_run}, 32'd0);
    check("t3_nowe2", alog.size(), 0);

    // Test 4: leading garbage, random FIFO stalls
    do_reset();
    rnd = 1'b1;
    q.push_back(8'h00);
    q.push_back(8'hFF);
    q.push_back(8'h12);
    push_frame(frame_ok);
    wait_run("t4_run", 800);
    rnd = 1'b0;
    check_log("t4");
    check("t4_drained", q.size(), 0);
    check("t4_err", {31'd0, boot_err}, 32'd0);

    // Test 5: reset during the third data byte
    do_reset();
    push_frame(frame_ok);
    lim = 0;
    while (last_byte != 8'h33 && lim < 200) begin
      @(negedge clk);
      lim++;
    end
    check("t5_reach", 32'(last_byte), 32'h33);
    rst = 1'b1;
    hold = 1'b1;
    @(negedge clk);
    check_zero("t5_rst");
    rst = 1'b0;
    q.delete();
    clear_logs();
    @(negedge clk);
    check_zero("t5_post");
    hold = 1'b0;
    push_frame(frame_ok);
    wait_run("t5_run", 300);
    check_log("t5");

`ifdef UART_BOOT_ECHO_EN
    // Test 6: echo with one dropped byte
    echo_exp = '{8'h55, 8'h02, 8'h00, 8'h11, 8'h22, 8'h44,
                 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h46};
    do_reset();
    full33 = 1'b1;
    push_frame(frame_ok);
    wait_run("t6_run", 300);
    repeat (4) @(negedge clk);
    full33 = 1'b0;
    check_log("t6");
    check("t6_txn", txlog.size(), 11);
    foreach (echo_exp[i])
      check($sformatf("t6_tx%0d", i),
            (txlog.size() > i) ? 32'(txlog[i]) : 32'hFFFF_FFFF,
            32'(echo_exp[i]));
`else
    bad[0] = 8'h00;
    echo_exp[0] = bad[0];
    check("noecho_tx", txlog.size(), 0);
`endif

    check("rd_empty", rd_bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
